// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - sequential ALU with valid/ready handshake; optional shift-add MUL under ALU_MUL_EN
module alu_seq_core #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // shift amounts at or above this value flush the operand to zero
    localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH-1:0] exec_res;
    logic             exec_carry;
    logic             exec_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // shift-add multiplier: one multiplier bit consumed per MUL cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state == S_IDLE && in_valid && op == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`endif

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // single-cycle datapath for every opcode handled in EXEC
    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_err   = 1'b0;
        case (op_q)
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            OP_ADD: begin
                exec_res   = sum[WIDTH-1:0];
                exec_carry = sum[WIDTH];
            end
            OP_SUB: begin
                exec_res   = diff[WIDTH-1:0];
                exec_carry = (a_q < b_q);
            end
            OP_SHL: exec_res = (b_q >= W_VAL) ? '0 : (a_q << b_q);
            OP_SHR: exec_res = (b_q >= W_VAL) ? '0 : (a_q >> b_q);
            default: begin
`ifdef ALU_MUL_EN
                exec_err = 1'b0;
`else
                exec_err = 1'b1;
`endif
            end
        endcase
    end

    // control FSM, operand capture and result registers (loaded only on entry to DONE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
`ifdef ALU_MUL_EN
                        state <= (op == OP_MUL) ? S_MUL : S_EXEC;
`else
                        state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    state  <= S_DONE;
                    result <= exec_res;
                    carry  <= exec_carry;
                    zero   <= (exec_res == '0);
                    err    <= exec_err;
                end
                S_MUL: begin
`ifdef ALU_MUL_EN
                    if (cnt == MUL_LAST) begin
                        state  <= S_DONE;
                        result <= acc_next[WIDTH-1:0];
                        carry  <= |acc_next[2*WIDTH-1:WIDTH];
                        zero   <= (acc_next[WIDTH-1:0] == '0);
                        err    <= 1'b0;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - directed table-driven bench for alu_seq_core
module tb_alu_seq_core;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_carry;
        logic         exp_zero;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[$];

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // edges after the accept edge until out_valid is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // called #1 after a rising edge with the DUT idle
    task automatic run_vec(input vec_t v);
        int lat;
        check({v.name, "_in_ready"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        op        = v.op;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        wait_done(lat);
        check({v.name, "_latency"}, lat, v.exp_lat);
        check({v.name, "_result"}, int'(result), int'(v.exp_res));
        check({v.name, "_carry"}, int'(carry), int'(v.exp_carry));
        check({v.name, "_zero"}, int'(zero), int'(v.exp_zero));
        check({v.name, "_err"}, int'(err), int'(v.exp_err));
        check({v.name, "_busy"}, int'(in_ready), 0);
        @(posedge clk);
        #1;
        check({v.name, "_release"}, int'(out_valid), 0);
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] o, input int va, input int vb,
                                input int r, input logic c, input logic z, input logic e, input int l);
        vec_t v;
        v.name = n; v.op = o; v.a = W'(va); v.b = W'(vb);
        v.exp_res = W'(r); v.exp_carry = c; v.exp_zero = z; v.exp_err = e; v.exp_lat = l;
        return v;
    endfunction

    initial begin
        int lat;
        int seen;

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;

        vecs.push_back(mk("and_7f_55",   3'b000, 127, 85,  85, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("or_40_05",    3'b001, 64,  5,   69, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("xor_same",    3'b010, 85,  85,  0,  1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("add_ovf",     3'b011, 100, 50,  22, 1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mk("add_max",     3'b011, 27,  100, 127,1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("add_wrap0",   3'b011, 1,   127, 0,  1'b1, 1'b1, 1'b0, 1));
        vecs.push_back(mk("sub_borrow",  3'b100, 5,   7,   126,1'b1, 1'b0, 1'b0, 1));
        vecs.push_back(mk("sub_equal",   3'b100, 7,   7,   0,  1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("sub_plain",   3'b100, 100, 36,  64, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shl_big",     3'b101, 1,   9,   0,  1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("shl_6",       3'b101, 3,   6,   64, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shl_w",       3'b101, 5,   7,   0,  1'b0, 1'b1, 1'b0, 1));
        vecs.push_back(mk("shr_6",       3'b110, 127, 6,   1,  1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shr_0",       3'b110, 64,  0,   64, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("shr_w",       3'b110, 127, 7,   0,  1'b0, 1'b1, 1'b0, 1));
`ifdef ALU_MUL_EN
        vecs.push_back(mk("mul_12_11",   3'b111, 12,  11,  4,  1'b1, 1'b0, 1'b0, W));
        vecs.push_back(mk("mul_9_3",     3'b111, 9,   3,   27, 1'b0, 1'b0, 1'b0, W));
        vecs.push_back(mk("mul_max",     3'b111, 127, 127, 1,  1'b1, 1'b0, 1'b0, W));
        vecs.push_back(mk("mul_zero",    3'b111, 0,   100, 0,  1'b0, 1'b1, 1'b0, W));
`else
        vecs.push_back(mk("mul_off",     3'b111, 3,   3,   0,  1'b0, 1'b1, 1'b1, 1));
`endif

        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_carry", int'(carry), 0);
        check("rst_zero", int'(zero), 0);
        check("rst_err", int'(err), 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // backpressure: held DONE ignores new requests
        in_valid = 1'b1; op = 3'b011; a = 7'd100; b = 7'd50; out_ready = 1'b0;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("bp_latency", lat, 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; op = 3'b000; a = '0; b = '0;
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_result", int'(result), 22);
            check("bp_carry", int'(carry), 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_out_valid", int'(out_valid), 0);
        check("bp_idle_in_ready", int'(in_ready), 1);
        check("bp_hold_result", int'(result), 22);
        @(posedge clk);
        #1;
        check("bp_no_phantom", int'(out_valid), 0);

`ifdef ALU_MUL_EN
        // reset in the third MUL cycle discards the multiply
        in_valid = 1'b1; op = 3'b111; a = 7'd12; b = 7'd11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("mulrst_pre_valid", int'(out_valid), 0);
`else
        // reset while an unsupported-op result is held in DONE
        in_valid = 1'b1; op = 3'b111; a = 7'd3; b = 7'd3; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check("donerst_err_before", int'(err), 1);
`endif
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_result", int'(result), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_zero", int'(zero), 0);
        check("midrst_err", int'(err), 0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);

        // first accept at the first rising edge after reset release
        rst = 1'b1;
        in_valid = 1'b1; op = 3'b000; a = 7'd127; b = 7'd85;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check("post_rst_latency", lat, 1);
        check("post_rst_result", int'(result), 85);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter WIDTH, default 7: operand and result width in bits, legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept an operation.
REQ-006 op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SHL, 110 SHR, 111 MUL.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; for SHL/SHR, b is the shift amount.
REQ-009 out_valid  output  1  result, carry, zero and err are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 carry  output  1  ADD carry-out, SUB borrow, or MUL overflow; 0 for all other opcodes.
REQ-013 zero  output  1  high when result is all zeros.
REQ-014 err  output  1  high when the opcode is unsupported in this build.

Function
REQ-015 FSM states: IDLE, EXEC, MUL, DONE; in_ready is 1 only in IDLE.
REQ-016 Accept: in_valid & in_ready at edge N captures op, a and b; inputs are ignored in every other state.
REQ-017 Non-MUL ops: IDLE -> EXEC at N; EXEC -> DONE at N+1; out_valid is high from cycle N+2.
REQ-018 MUL: IDLE -> MUL at N; WIDTH shift-add iterations, one per cycle; then -> DONE, with out_valid high from cycle N+WIDTH+1.
REQ-019 DONE: outputs are held stable while out_ready=0; out_valid & out_ready -> IDLE on the next edge; there is no accept in the same cycle.
REQ-020 ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
REQ-021 SUB: result = (a-b) mod 2^WIDTH; carry = 1 iff a < b (unsigned).
REQ-022 SHL/SHR: logical shift by the unsigned value of b; b >= WIDTH gives result 0; carry = 0.
REQ-023 MUL: result = low WIDTH bits of the unsigned product; carry = 1 iff any upper WIDTH bits are nonzero.
REQ-024 zero is computed from the final registered result for every opcode, including err cases.
REQ-025 out_valid is low in IDLE, EXEC and MUL; result, carry, zero and err hold their previous values outside DONE.

Reset
REQ-026 rst=1 forces state IDLE, in_ready=1, out_valid=0, result=0, carry=0, zero=0, err=0 immediately, independent of clk.
REQ-027 Reset asserted mid-MUL or in DONE discards the operation; no out_valid follows it.
REQ-028 After rst deasserts, the first accept is possible at the first rising edge.

Configuration
REQ-029 Macro ALU_MUL_EN defined: the MUL state and shift-add datapath are compiled in, and op 111 behaves per REQ-018/REQ-023.
REQ-030 ALU_MUL_EN undefined: no multiplier logic is built; op 111 follows the REQ-017 timing with result=0, carry=0, zero=1, err=1; err=0 for all other ops in both builds.

Verification (WIDTH=7, ALU_MUL_EN defined unless stated)
REQ-031 AND: a=127, b=85 -> result=85, zero=0, carry=0, out_valid at N+2.
REQ-032 ADD: a=100, b=50 -> result=22, carry=1; SUB a=5, b=7 -> result=126, carry=1; SUB a=7, b=7 -> result=0, zero=1.
REQ-033 MUL: a=12, b=11 -> result=4, carry=1, out_valid exactly at N+8; a=9, b=3 -> result=27, carry=0.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset: rst pulsed in the 3rd MUL cycle -> out_valid=0 and result=0 immediately, in_ready=1, and no result is produced for that operation.
REQ-036 Build without ALU_MUL_EN: op=111, a=3, b=3 -> result=0, err=1, zero=1 at N+2; SHL a=1, b=9 -> result=0.
